nf_trace_buf: RTL and testbench

Hardware retirement-trace buffer for the nanoFOX pipeline. It sits directly downstream of the CPU write-back stage. On every retired instruction it captures the PC, the instruction word, the register-file write and a cycle timestamp into an on-chip FIFO. Software or a debug bridge drains the FIFO over a valid/ready port, so the per-cycle pipeline log is also available on silicon.

---
 rtl/nf_trace_buf.sv | 142 ++++++++++++++
 tb/tb_nf_trace_buf.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_trace_buf.sv
// nf_trace_buf: retirement-trace FIFO sitting behind the nanoFOX write-back stage.
// Captures {cycle, pc, instr, we, rd, wd} per retired instruction and presents
// the oldest entry first-word-fall-through on a valid/ready drain port.
module nf_trace_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wrap,
    input  logic                     clr,
    input  logic                     wb_vld,
    input  logic [31:0]              wb_pc,
    input  logic [31:0]              wb_instr,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_wd,
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [CNT_W-1:0]         t_cycle,
    output logic [31:0]              t_pc,
    output logic [31:0]              t_instr,
    output logic                     t_we,
    output logic [4:0]               t_rd,
    output logic [31:0]              t_wd,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     ovf,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [CNT_W-1:0] cyc;
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic             we;
        logic [4:0]       rd;
        logic [31:0]      wd;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CNT_W-1:0] cyc;

    logic push;
    logic pop;
    logic is_full;
    logic do_write;
    logic adv_wp;
    logic adv_rp;
    logic inc_cnt;
    logic dec_cnt;
    logic lost;

    // Free-running timestamp; only rst clears it, clr leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + CNT_W'(1);
    end

    // Decode push/pop into pointer, count and loss actions for this cycle.
    always_comb begin
        push     = wb_vld && en && !clr;
        pop      = (count != '0) && t_ready && !clr;
        is_full  = (count == CW'(DEPTH));
        do_write = 1'b0;
        adv_wp   = 1'b0;
        adv_rp   = 1'b0;
        inc_cnt  = 1'b0;
        dec_cnt  = 1'b0;
        lost     = 1'b0;
        if (push && pop) begin
            do_write = 1'b1;
            adv_wp   = 1'b1;
            adv_rp   = 1'b1;
        end else if (push && !is_full) begin
            do_write = 1'b1;
            adv_wp   = 1'b1;
            inc_cnt  = 1'b1;
        end else if (push) begin
            // Full with no pop: overwrite mode slides the window by one,
            // drop mode discards the newcomer; both count as a loss.
            lost = 1'b1;
            if (wrap) begin
                do_write = 1'b1;
                adv_wp   = 1'b1;
                adv_rp   = 1'b1;
            end
        end else if (pop) begin
            adv_rp  = 1'b1;
            dec_cnt = 1'b1;
        end
    end

    // Pointer, occupancy and loss-tracking registers.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (adv_wp) wp <= wp + AW'(1);
            if (adv_rp) rp <= rp + AW'(1);
            if (inc_cnt)      count <= count + CW'(1);
            else if (dec_cnt) count <= count - CW'(1);
            if (lost) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Entry storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem[wp] <= '{cyc: cyc, pc: wb_pc, instr: wb_instr, we: wb_we,
                         rd: wb_rd, wd: wb_wd};
        end
    end

    // First-word-fall-through head; rd/wd are masked when the entry has no write.
    always_comb begin
        head    = mem[rp];
        t_valid = (count != '0);
        full    = is_full;
        t_cycle = head.cyc;
        t_pc    = head.pc;
        t_instr = head.instr;
        t_we    = head.we;
        t_rd    = head.we ? head.rd : '0;
        t_wd    = head.we ? head.wd : '0;
    end

endmodule

// File: tb/tb_nf_trace_buf.sv
// Self-checking bench for nf_trace_buf: directed table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_nf_trace_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst, en, wrap, clr, wb_vld, wb_we, t_ready;
    logic [31:0] wb_pc, wb_instr, wb_wd;
    logic [4:0]  wb_rd;
    logic        t_valid, t_we, full, ovf;
    logic [CNT_W-1:0] t_cycle;
    logic [31:0] t_pc, t_instr, t_wd;
    logic [4:0]  t_rd;
    logic [$clog2(DEPTH):0] count;
    logic [15:0] drop_cnt;

    nf_trace_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .wrap(wrap), .clr(clr),
        .wb_vld(wb_vld), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_we(wb_we),
        .wb_rd(wb_rd), .wb_wd(wb_wd),
        .t_valid(t_valid), .t_ready(t_ready), .t_cycle(t_cycle), .t_pc(t_pc),
        .t_instr(t_instr), .t_we(t_we), .t_rd(t_rd), .t_wd(t_wd),
        .count(count), .full(full), .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: an ordered list of captured entries plus loss counters.
    typedef struct {
        logic [31:0] cyc;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_cyc;
    logic [15:0] m_drop;
    logic        m_ovf;

    typedef struct {
        logic        vld;
        logic        en;
        logic        clr;
        logic        rdy;
        logic [31:0] pc;
        int          e_cnt;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("count", 64'(count), 64'(q.size()));
        chk("t_valid", 64'(t_valid), 64'(q.size() != 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (q.size() != 0) begin
            chk("t_cycle", 64'(t_cycle), 64'(q[0].cyc));
            chk("t_pc", 64'(t_pc), 64'(q[0].pc));
            chk("t_instr", 64'(t_instr), 64'(q[0].instr));
            chk("t_we", 64'(t_we), 64'(q[0].we));
            chk("t_rd", 64'(t_rd), 64'(q[0].rd));
            chk("t_wd", 64'(t_wd), 64'(q[0].wd));
        end
    endtask

    // Advance the model by the rules for the inputs currently applied,
    // clock the DUT, then compare a little after the edge.
    task automatic step();
        ent_t e;
        bit   push, pop;
        if (rst || clr) begin
            q.delete();
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            push    = wb_vld && en;
            pop     = (q.size() != 0) && t_ready;
            e.cyc   = m_cyc;
            e.pc    = wb_pc;
            e.instr = wb_instr;
            e.we    = wb_we;
            e.rd    = wb_we ? wb_rd : 5'd0;
            e.wd    = wb_we ? wb_wd : 32'd0;
            if (push && !pop && q.size() == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                if (wrap) begin
                    void'(q.pop_front());
                    q.push_back(e);
                end
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
        end
        m_cyc = rst ? 32'd0 : m_cyc + 32'd1;
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        wb_vld   = v;
        en       = 1'b1;
        wb_pc    = pc;
        wb_instr = pc ^ 32'hA5A5_0000;
        wb_we    = pc[2];
        wb_rd    = pc[6:2];
        wb_wd    = ~pc;
    endtask

    task automatic flush();
        clr = 1'b1; drive(1'b0, 32'd0); t_ready = 1'b0;
        step();
        clr = 1'b0;
    endtask

    task automatic fill_drain(input logic w, input int first);
        flush();
        wrap = w;
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 32'h1000 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'd0);
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_drop", 64'(drop_cnt), 64'd2);
        chk("fill_ovf", 64'(ovf), 64'd1);
        t_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_pc", 64'(t_pc), 64'(32'h1000 + 32'(4 * (i + first))));
            step();
        end
        t_ready = 1'b0;
        chk("drain_empty", 64'(t_valid), 64'd0);
    endtask

    initial begin
        tbl[0] = '{vld:1, en:0, clr:0, rdy:0, pc:32'h0F0, e_cnt:0, e_vld:0, e_pc:32'h0};
        tbl[1] = '{vld:1, en:1, clr:0, rdy:0, pc:32'h100, e_cnt:1, e_vld:1, e_pc:32'h100};
        tbl[2] = '{vld:1, en:1, clr:0, rdy:1, pc:32'h104, e_cnt:1, e_vld:1, e_pc:32'h104};
        tbl[3] = '{vld:0, en:1, clr:0, rdy:1, pc:32'h0,   e_cnt:0, e_vld:0, e_pc:32'h0};
        tbl[4] = '{vld:0, en:1, clr:0, rdy:1, pc:32'h0,   e_cnt:0, e_vld:0, e_pc:32'h0};
        tbl[5] = '{vld:1, en:1, clr:0, rdy:0, pc:32'h108, e_cnt:1, e_vld:1, e_pc:32'h108};
        tbl[6] = '{vld:1, en:1, clr:1, rdy:0, pc:32'h10C, e_cnt:0, e_vld:0, e_pc:32'h0};
        tbl[7] = '{vld:1, en:1, clr:0, rdy:0, pc:32'h110, e_cnt:1, e_vld:1, e_pc:32'h110};
        tbl[8] = '{vld:0, en:1, clr:0, rdy:1, pc:32'h0,   e_cnt:0, e_vld:0, e_pc:32'h0};

        rst = 1'b1; clr = 1'b0; wrap = 1'b0; t_ready = 1'b0;
        drive(1'b0, 32'd0);
        m_cyc = '0; m_drop = '0; m_ovf = 1'b0;

        // Reset for three cycles, then a single capture at timestamp 5.
        for (int i = 0; i < 3; i++) step();
        chk("rst_valid", 64'(t_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        wb_vld = 1'b1; en = 1'b1; wb_pc = 32'h0000_0010; wb_instr = 32'h0010_0093;
        wb_we = 1'b1; wb_rd = 5'd1; wb_wd = 32'd1;
        step();
        drive(1'b0, 32'd0);
        chk("basic_valid", 64'(t_valid), 64'd1);
        chk("basic_cycle", 64'(t_cycle), 64'd5);
        chk("basic_rd", 64'(t_rd), 64'd1);
        chk("basic_wd", 64'(t_wd), 64'd1);
        chk("basic_count", 64'(count), 64'd1);

        // Directed vector table: enable gating, push+pop, empty pop, clr priority.
        flush();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].vld, tbl[i].pc);
            en      = tbl[i].en;
            clr     = tbl[i].clr;
            t_ready = tbl[i].rdy;
            step();
            chk("tbl_count", 64'(count), 64'(tbl[i].e_cnt));
            chk("tbl_valid", 64'(t_valid), 64'(tbl[i].e_vld));
            if (tbl[i].e_vld) chk("tbl_pc", 64'(t_pc), 64'(tbl[i].e_pc));
            chk("tbl_drop", 64'(drop_cnt), 64'd0);
        end
        clr = 1'b0; t_ready = 1'b0; drive(1'b0, 32'd0);

        // Full-buffer policies.
        fill_drain(1'b0, 0);
        fill_drain(1'b1, 2);
        wrap = 1'b0;

        // Simultaneous push and pop at full and at one entry; pop on empty.
        flush();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i));
            step();
        end
        drive(1'b1, 32'h2000); t_ready = 1'b1;
        step();
        chk("pp_full_count", 64'(count), 64'd16);
        chk("pp_full_drop", 64'(drop_cnt), 64'd0);
        chk("pp_full_head", 64'(t_pc), 64'h3004);
        drive(1'b0, 32'd0);
        for (int i = 0; i < 15; i++) step();
        chk("pp_one_count", 64'(count), 64'd1);
        chk("pp_one_head", 64'(t_pc), 64'h2000);
        drive(1'b1, 32'h2004);
        step();
        chk("pp_one_count2", 64'(count), 64'd1);
        chk("pp_one_head2", 64'(t_pc), 64'h2004);
        drive(1'b0, 32'd0);
        step();
        step();
        chk("pop_empty_count", 64'(count), 64'd0);
        chk("pop_empty_valid", 64'(t_valid), 64'd0);
        t_ready = 1'b0;

        // Backpressure, then a 16-beat back-to-back drain.
        flush();
        drive(1'b1, 32'h4000);
        step();
        drive(1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(t_valid), 64'd1);
            chk("bp_pc", 64'(t_pc), 64'h4000);
        end
        flush();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'h5000 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'd0); t_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("burst_valid", 64'(t_valid), 64'd1);
            chk("burst_pc", 64'(t_pc), 64'(32'h5000 + 32'(4 * i)));
            step();
        end
        t_ready = 1'b0;
        chk("burst_done", 64'(t_valid), 64'd0);

        // clr mid-operation with losses pending.
        flush();
        for (int i = 0; i < 18; i++) begin
            drive(1'b1, 32'h6000 + 32'(4 * i));
            step();
        end
        drive(1'b0, 32'd0); t_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        t_ready = 1'b0;
        chk("pre_clr_count", 64'(count), 64'd8);
        clr = 1'b1; drive(1'b1, 32'h7000);
        step();
        clr = 1'b0;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_ovf", 64'(ovf), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        drive(1'b1, 32'h7004);
        step();
        chk("post_clr_pc", 64'(t_pc), 64'h7004);

        // rst mid-burst: timestamp restarts at 0.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h7100 + 32'(4 * i));
            step();
        end
        chk("pre_rst_count", 64'(count), 64'd8);
        rst = 1'b1; drive(1'b1, 32'h7200);
        step();
        rst = 1'b0;
        chk("rst_mid_count", 64'(count), 64'd0);
        drive(1'b1, 32'h8000);
        step();
        chk("post_rst_cycle", 64'(t_cycle), 64'd0);
        drive(1'b0, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wb_vld   = ($urandom_range(0, 99) < 60);
            en       = ($urandom_range(0, 9) != 0);
            wrap     = ($urandom_range(0, 63) < 32) ? wrap : ~wrap;
            clr      = ($urandom_range(0, 149) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            t_ready  = ($urandom_range(0, 99) < 45);
            wb_pc    = $urandom;
            wb_instr = $urandom;
            wb_we    = $urandom_range(0, 1);
            wb_rd    = 5'($urandom_range(0, 31));
            wb_wd    = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
